// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: steps the T0-T2 strobes, waits on memory in T1
// with a bounded timeout, and counts completed fetches.
module fetch_sequencer #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int COUNT_WIDTH  = 8
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic                   start,
    input  logic                   stall,
    input  logic                   mem_ready,
    input  logic                   err_ack,
    output logic                   PCout,
    output logic                   MARin,
    output logic                   IncPC,
    output logic                   Zin,
    output logic                   Zlowout,
    output logic                   PCin,
    output logic                   Read,
    output logic                   MDRin,
    output logic                   MDRout,
    output logic                   IRin,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout,
    output logic [COUNT_WIDTH-1:0] fetch_count
);

    localparam int WAIT_WIDTH = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [WAIT_WIDTH-1:0] LAST_WAIT = WAIT_WIDTH'(MEM_WAIT_MAX - 1);

    typedef enum logic [2:0] {IDLE, T0, T1, T2, ERR} stateType;

    stateType               state;
    stateType               nextState;
    logic [WAIT_WIDTH-1:0]  waitCount;
    logic                   firstT1;
    logic                   waitExpired;

    // waitCount holds the number of T1 cycles already spent without mem_ready.
    assign firstT1     = (waitCount == '0);
    assign waitExpired = (waitCount == LAST_WAIT);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state       <= IDLE;
            waitCount   <= '0;
            fetch_count <= '0;
        end else begin
            state <= nextState;
            if (state == T1 && !mem_ready && !waitExpired)
                waitCount <= waitCount + WAIT_WIDTH'(1);
            else
                waitCount <= '0;
            if (state == T2)
                fetch_count <= fetch_count + COUNT_WIDTH'(1);
        end
    end

    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        nextState = state;
        PCout     = 1'b0;
        MARin     = 1'b0;
        IncPC     = 1'b0;
        Zin       = 1'b0;
        Zlowout   = 1'b0;
        PCin      = 1'b0;
        Read      = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        IRin      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stall) nextState = T0;
            end
            T0: begin
                PCout     = 1'b1;
                MARin     = 1'b1;
                IncPC     = 1'b1;
                Zin       = 1'b1;
                busy      = 1'b1;
                nextState = T1;
            end
            T1: begin
                busy    = 1'b1;
                Read    = 1'b1;
                Zlowout = firstT1;
                PCin    = firstT1;
                MDRin   = mem_ready;
                if (mem_ready)        nextState = T2;
                else if (waitExpired) nextState = ERR;
            end
            T2: begin
                busy      = 1'b1;
                MDRout    = 1'b1;
                IRin      = 1'b1;
                done      = 1'b1;
                nextState = (start && !stall) ? T0 : IDLE;
            end
            ERR: begin
                timeout = 1'b1;
                if (err_ack) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Only one source may drive the bus in any cycle.
    busExclusive: assert property (@(posedge clock) disable iff (!clear)
        $onehot0({PCout, Zlowout, MDRout}));

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Control sequencer for the instruction-fetch phase of the bus-based datapath. It drives the register-file and special-register strobes (PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin) through the fetch steps T0–T2, handshakes with memory, and reports completion and timeout to the downstream decode/execute controller. Each strobe drives one destination register's `enable` or one source's bus-out select; only one bus source is active per cycle.

## Interface
- MEM_WAIT_MAX, 15: maximum cycles spent in T1 waiting for `mem_ready`; must be ≥ 1.
- COUNT_WIDTH, 8: width of the completed-fetch counter.

- clock  in  1  rising-edge clock.
- clear  in  1  reset, asynchronous, active-low.
- start  in  1  level request to fetch; sampled in IDLE and in T2.
- stall  in  1  blocks entry into T0 while high.
- mem_ready  in  1  memory read data valid on the memory data input this cycle.
- err_ack  in  1  clears ERR state.
- PCout, MARin, IncPC, Zin  out  1 each  T0 strobes.
- Zlowout, PCin  out  1 each  first-cycle T1 strobes.
- Read  out  1  memory read request.
- MDRin  out  1  MDR load enable.
- MDRout, IRin  out  1 each  T2 strobes.
- busy  out  1  high in T0, T1, T2.
- done  out  1  one-cycle pulse, coincident with IRin.
- timeout  out  1  high while in ERR.
- fetch_count  out  COUNT_WIDTH  completed fetches, modulo 2^COUNT_WIDTH.

## Operation
- States: IDLE, T0, T1, T2, ERR. Reset (clear=0) forces IDLE, wait counter 0, fetch_count 0, all outputs 0, immediately and regardless of clock.
- IDLE: if start=1 and stall=0 → T0, else stay.
- T0: assert PCout, MARin, IncPC, Zin → T1 unconditionally.
- T1: Read=1 every T1 cycle. Zlowout and PCin only in the first T1 cycle, so PC is loaded exactly once per fetch. MDRin = mem_ready (combinational, T1 only).
  - mem_ready=1 → T2, wait counter cleared.
  - mem_ready=0 and this is the MEM_WAIT_MAX-th T1 cycle → ERR.
  - otherwise stay in T1 and increment the wait counter.
- T2: assert MDRout, IRin, done; fetch_count increments (wraps from all-ones to 0). Then start=1 and stall=0 → T0 (back-to-back fetch), else IDLE.
- ERR: timeout=1, all strobes 0, busy=0. err_ack=1 → IDLE; start is ignored. fetch_count is unchanged.
- stall is sampled only on the IDLE→T0 and T2→T0 decisions. It has no effect in T0 or T1.
- At most one of PCout, Zlowout, MDRout is high in any cycle (bus exclusivity). This is a checked invariant.
- mem_ready outside T1 is ignored.

## Timing
- Outputs are registered-state decodes (Moore), except MDRin, which is a combinational AND of state T1 and mem_ready.
- start sampled high at edge n → T0 in cycle n+1.
- Minimum fetch is 3 cycles (T0, T1, T2) when mem_ready=1 in the first T1 cycle. Each T1 cycle without mem_ready adds 1 cycle.
- Back-to-back fetches: T2 is followed directly by T0, giving 3 cycles per fetch with no idle gap.
- ERR is entered on the edge after the MEM_WAIT_MAX-th T1 cycle without mem_ready. mem_ready arriving in that same final cycle wins (→ T2).
- err_ack high at edge m → IDLE in cycle m+1. A new fetch can therefore start no earlier than cycle m+2.
- clear asserted mid-fetch aborts it: strobes drop asynchronously, done is not produced, and the count is not incremented.

## Test plan
- Single fetch: clear released, start=1 for 1 cycle, mem_ready=1 in the first T1 cycle → T0/T1/T2 strobes in 3 consecutive cycles, done pulses once, fetch_count=1, PCin high exactly 1 cycle.
- Memory wait: mem_ready delayed 4 cycles → T1 lasts 5 cycles, Read high all 5, MDRin high only in the 5th, Zlowout/PCin only in the 1st.
- Timeout: MEM_WAIT_MAX=15, mem_ready never asserted → timeout=1 after 15 T1 cycles. start ignored; err_ack → IDLE. Separately, mem_ready in the 15th cycle → T2, no timeout.
- Back-to-back with stall: start held high for 3 fetches, then stall=1 during the 3rd T2 → 3 done pulses 3 cycles apart, then IDLE. Releasing stall resumes with T0 next cycle.
- Reset mid-fetch: clear=0 during T1 → all outputs 0 immediately, fetch_count=0, state IDLE after release.
- Wrap: COUNT_WIDTH=2, 5 fetches → fetch_count sequence 1, 2, 3, 0, 1. Bus-exclusivity assertion holds throughout.
